// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard: default address width,
// forward-select encodings, standard producer latencies and bus indices.
package hazard_scoreboard_pkg;

    localparam int DEF_REG_ADDR = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    localparam logic [2:0] LAT_ALU  = 3'd0;
    localparam logic [2:0] LAT_LOAD = 3'd1;
    localparam logic [2:0] LAT_MUL  = 3'd3;

    localparam logic [1:0] BUS_ALU  = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

endpackage

// File: rtl/hazard_scoreboard_chk.sv
// Simulation-only checks on the scoreboard's issue interface.
module hazard_scoreboard_chk #(
    parameter int SEL_W   = 2,
    parameter int NUM_FWD = 2
) (
    input logic             clk,
    input logic             reset,
    input logic             issue_valid,
    input logic             issue_regwrite,
    input logic [SEL_W-1:0] issue_bus
);

    // Flags a write-back issue naming a bus that does not exist.
    always @(posedge clk) begin
        if (!reset && issue_valid && issue_regwrite) begin
            assert (issue_bus < SEL_W'(NUM_FWD));
        end
    end

endmodule

// File: rtl/hazard_scoreboard_entry.sv
// One register's in-flight producer state: busy flag, cycles until the result
// reaches a bypass bus, and which bus it currently sits on.
module sb_entry #(
    parameter int LAT_W   = 3,
    parameter int SEL_W   = 2,
    parameter int NUM_FWD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_alloc,
    input  logic [LAT_W-1:0] i_lat,
    input  logic [SEL_W-1:0] i_bus,
    output logic             o_busy,
    output logic [LAT_W-1:0] o_cnt,
    output logic [SEL_W-1:0] o_idx
);

    logic             r_busy;
    logic [LAT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_idx;

    // Allocation overrides the tick so a re-issued register takes the younger producer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else if (i_alloc) begin
            r_busy <= 1'b1;
            r_cnt  <= i_lat;
            r_idx  <= i_bus;
        end else if (i_tick && r_busy) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - LAT_W'(1);
            end else if (r_idx == SEL_W'(NUM_FWD - 1)) begin
                // Oldest bus passed: the value now lives in the register file.
                r_busy <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx <= r_idx + SEL_W'(1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;
    assign o_idx  = r_idx;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: per-register in-flight tracking with variable producer
// latency, yielding per-source bypass selects and a single ID stall.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int REG_ADDR = DEF_REG_ADDR,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_SRC  = 2,
    parameter  int NUM_FWD  = 2,
    parameter  int LAT_W    = 3,
    localparam int SEL_W    = $clog2(NUM_FWD + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_ADDR-1:0] src_addr,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic                        issue_valid,
    input  logic                        issue_regwrite,
    input  logic [REG_ADDR-1:0]         issue_dst,
    input  logic [LAT_W-1:0]            issue_lat,
    input  logic [SEL_W-1:0]            issue_bus,
    input  logic                        freeze,
    output logic                        stall,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic [NUM_REGS-1:0]         busy_vec
);

    logic [NUM_REGS-1:0]      w_busy;
    logic [LAT_W-1:0]         w_cnt [NUM_REGS];
    logic [SEL_W-1:0]         w_idx [NUM_REGS];
    logic [SEL_W-1:0]         w_bus;
    logic                     w_stall;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic                     w_alloc_any;

    // Register 0 is hardwired and never tracked.
    assign w_busy[0] = 1'b0;
    assign w_cnt[0]  = '0;
    assign w_idx[0]  = '0;

    // Clamp an out-of-range bus index onto the oldest bus.
    always_comb begin
        if (issue_bus >= SEL_W'(NUM_FWD)) begin
            w_bus = SEL_W'(NUM_FWD - 1);
        end else begin
            w_bus = issue_bus;
        end
    end

    // Per-source lookup from registered state only, so the issuing instruction sees pre-update entries.
    always_comb begin
        w_stall = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && w_busy[src_addr[i*REG_ADDR +: REG_ADDR]]) begin
                if (w_cnt[src_addr[i*REG_ADDR +: REG_ADDR]] != '0) begin
                    w_stall = 1'b1;
                end else begin
                    w_sel[i*SEL_W +: SEL_W] = w_idx[src_addr[i*REG_ADDR +: REG_ADDR]] + SEL_W'(1);
                end
            end else begin
                w_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
            end
        end
    end

    assign w_alloc_any = issue_valid & issue_regwrite & (issue_dst != '0) & ~w_stall & ~freeze;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
        sb_entry #(
            .LAT_W  (LAT_W),
            .SEL_W  (SEL_W),
            .NUM_FWD(NUM_FWD)
        ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .i_tick (~freeze),
            .i_alloc(w_alloc_any && (issue_dst == REG_ADDR'(g))),
            .i_lat  (issue_lat),
            .i_bus  (w_bus),
            .o_busy (w_busy[g]),
            .o_cnt  (w_cnt[g]),
            .o_idx  (w_idx[g])
        );
    end

    hazard_scoreboard_chk #(
        .SEL_W  (SEL_W),
        .NUM_FWD(NUM_FWD)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_regwrite(issue_regwrite),
        .issue_bus     (issue_bus)
    );

    assign stall    = w_stall;
    assign fwd_sel  = w_sel;
    assign busy_vec = w_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, freeze sequence, and random
// stimulus against a time-stamp based reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        issue_valid;
    logic        issue_regwrite;
    logic [4:0]  issue_dst;
    logic [2:0]  issue_lat;
    logic [1:0]  issue_bus;
    logic        freeze;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [31:0] busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .src_addr      (src_addr),
        .src_used      (src_used),
        .issue_valid   (issue_valid),
        .issue_regwrite(issue_regwrite),
        .issue_dst     (issue_dst),
        .issue_lat     (issue_lat),
        .issue_bus     (issue_bus),
        .freeze        (freeze),
        .stall         (stall),
        .fwd_sel       (fwd_sel),
        .busy_vec      (busy_vec)
    );

    typedef struct {
        bit          rst;
        bit          iv;
        int          dst;
        int          lat;
        int          bus;
        bit          frz;
        int          s0;
        int          s1;
        int          used;
        bit          e_stall;
        logic [1:0]  e_sel0;
        logic [1:0]  e_sel1;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit iv, int dst, int lat, int bus, bit frz,
                                int s0, int s1, int used, bit es, int e0, int e1,
                                logic [31:0] eb);
        vec_t v;
        v.rst = rst; v.iv = iv; v.dst = dst; v.lat = lat; v.bus = bus; v.frz = frz;
        v.s0 = s0; v.s1 = s1; v.used = used;
        v.e_stall = es; v.e_sel0 = 2'(e0); v.e_sel1 = 2'(e1); v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit iv, input bit rw, input int dst,
                         input int lat, input int bus, input bit frz,
                         input int s0, input int s1, input int used);
        reset          = rst;
        issue_valid    = iv;
        issue_regwrite = rw;
        issue_dst      = 5'(dst);
        issue_lat      = 3'(lat);
        issue_bus      = 2'(bus);
        freeze         = frz;
        src_addr       = {5'(s1), 5'(s0)};
        src_used       = 2'(used);
    endtask

    // Reference model: each tracked register remembers the tick-time at which its
    // result first appears and on which bus; it then moves one bus older per tick.
    bit m_valid  [32];
    int m_appear [32];
    int m_bus    [32];
    int m_time;

    initial begin
        int stall_cycles;
        bit exp_stall;
        logic [1:0] exp_sel [2];
        logic [31:0] exp_busy;
        bit r_rst, r_iv, r_rw, r_frz;
        int r_dst, r_lat, r_bus, r_s0, r_s1, r_used;

        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_stall", stall, 1'b0);
        chk("reset_sel", fwd_sel, 4'h0);
        chk("reset_busy", busy_vec, 32'h0);

        // ALU chain on r3
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 32'h1 << 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 2, 0, 32'h1 << 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 32'h0));
        // Load-use on r5; the stalled consumer must not allocate r8
        tbl.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 8, 0, 0, 0, 0, 5, 2, 1, 0, 0, 32'h1 << 5));
        tbl.push_back(mk(0, 1, 8, 0, 0, 0, 0, 5, 2, 0, 0, 2, 32'h1 << 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8, 5, 3, 0, 1, 0, 32'h1 << 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        // WAW on r7: younger ALU producer replaces the multi-cycle one
        tbl.push_back(mk(0, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0, 32'h1 << 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 2, 0, 32'h1 << 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 32'h0));
        // r0 is never tracked
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 32'h0));
        // Unused source on busy r4, then reset mid-flight
        tbl.push_back(mk(0, 1, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 32'h1 << 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 32'h1 << 4));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 4, 0, 1, 1, 0, 0, 32'h1 << 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 4, 3, 0, 0, 0, 32'h0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].iv, tbl[k].iv, tbl[k].dst, tbl[k].lat, tbl[k].bus,
                  tbl[k].frz, tbl[k].s0, tbl[k].s1, tbl[k].used);
            #1;
            chk($sformatf("vec%0d_stall", k), stall, tbl[k].e_stall);
            chk($sformatf("vec%0d_sel0", k), fwd_sel[1:0], tbl[k].e_sel0);
            chk($sformatf("vec%0d_sel1", k), fwd_sel[3:2], tbl[k].e_sel1);
            chk($sformatf("vec%0d_busy", k), busy_vec, tbl[k].e_busy);
        end

        // Multi-cycle producer r6 with two frozen cycles inside the stall window
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 6, 3, 0, 1'b0, 0, 0, 0);
        stall_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 9, 0, 0, (stall_cycles == 1 || stall_cycles == 2),
                  6, 0, 1);
            #1;
            if (!stall) break;
            stall_cycles++;
        end
        chk("frz_stall_cycles", stall_cycles, 5);
        chk("frz_sel0", fwd_sel[1:0], 2'd1);
        chk("frz_no_alloc_r9", busy_vec[9], 1'b0);

        // Random phase against the reference model
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
        for (int r = 0; r < 32; r++) m_valid[r] = 1'b0;
        m_time = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            r_rst  = ($urandom_range(0, 99) == 0);
            r_iv   = ($urandom_range(0, 3) != 0);
            r_rw   = ($urandom_range(0, 3) != 0);
            r_dst  = $urandom_range(0, 7);
            r_lat  = $urandom_range(0, 7);
            r_bus  = $urandom_range(0, 1);
            r_frz  = ($urandom_range(0, 5) == 0);
            r_s0   = $urandom_range(0, 7);
            r_s1   = $urandom_range(0, 7);
            r_used = $urandom_range(0, 3);
            drive(r_rst, r_iv, r_rw, r_dst, r_lat, r_bus, r_frz, r_s0, r_s1, r_used);
            #1;

            exp_stall = 1'b0;
            for (int i = 0; i < 2; i++) begin
                int a;
                int d;
                a = (i == 0) ? r_s0 : r_s1;
                exp_sel[i] = 2'd0;
                if (r_used[i] && a != 0 && m_valid[a]) begin
                    d = m_time - m_appear[a];
                    if (d < 0) exp_stall = 1'b1;
                    else if (m_bus[a] + d < 2) exp_sel[i] = 2'(m_bus[a] + d + 1);
                end
            end
            for (int r = 0; r < 32; r++) begin
                exp_busy[r] = m_valid[r] && (m_bus[r] + m_time - m_appear[r] < 2);
            end
            chk($sformatf("rnd%0d_stall", cyc), stall, exp_stall);
            chk($sformatf("rnd%0d_sel", cyc), fwd_sel, {exp_sel[1], exp_sel[0]});
            chk($sformatf("rnd%0d_busy", cyc), busy_vec, exp_busy);

            if (r_rst) begin
                for (int r = 0; r < 32; r++) m_valid[r] = 1'b0;
            end else if (!r_frz) begin
                m_time++;
                if (r_iv && r_rw && r_dst != 0 && !exp_stall) begin
                    m_valid[r_dst]  = 1'b1;
                    m_appear[r_dst] = m_time + r_lat;
                    m_bus[r_dst]    = r_bus;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational forwarding/stall logic.
- Keeps a per-register scoreboard of in-flight results with variable producer latency (ALU, load, multi-cycle mul/div).
- Sits in the decode stage. Per ID source operand it returns a registered-state-based bypass select, plus a single stall when any used source is not yet on any bypass bus.
- Supports NUM_SRC source ports and NUM_FWD bypass buses. Bus index 0 is nearest to EX (EX/MEM); bus index 1 is MEM/WB.

Parameters:
- REG_ADDR, 5, register address width.
- NUM_REGS, 32, number of architectural registers (must equal 2**REG_ADDR).
- NUM_SRC, 2, source operands looked up per cycle.
- NUM_FWD, 2, number of bypass buses, ordered youngest to oldest.
- LAT_W, 3, width of the issue latency field.
- SEL_W, derived localparam = clog2(NUM_FWD+1), width of one forward select.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- src_addr  in  NUM_SRC*REG_ADDR  ID source register addresses, packed, source 0 in LSBs
- src_used  in  NUM_SRC  source i is actually read by the ID instruction
- issue_valid  in  1  ID instruction leaves ID this cycle
- issue_regwrite  in  1  issuing instruction writes the RF
- issue_dst  in  REG_ADDR  destination register
- issue_lat  in  LAT_W  cycles before the result first appears on a bypass bus (0 = next cycle)
- issue_bus  in  SEL_W  0-based bus index where the result first appears (ALU 0, load 1)
- freeze  in  1  global pipeline freeze (cache miss)
- stall  out  1  hold IF/ID, inject bubble
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = RF, k = bypass bus k-1
- busy_vec  out  NUM_REGS  registered busy bit per register

Behaviour:
- Entry per register: busy, ready_cnt[LAT_W], fwd_idx[SEL_W]. Register 0 is never busy.
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all entries cleared. Consequently busy_vec=0, stall=0, fwd_sel=0. Reset mid-operation discards all in-flight state in the same edge.
- Lookup, combinational from registered state, for each source i:
  - not src_used[i], or addr==0, or entry not busy: sel 0, no stall contribution.
  - busy and ready_cnt>0: stall contribution, sel 0.
  - busy and ready_cnt==0: sel = fwd_idx+1.
- stall = OR of all stall contributions.
- Allocation: occurs when issue_valid & issue_regwrite & issue_dst!=0 & ~stall & ~freeze. It sets busy=1, ready_cnt=issue_lat, fwd_idx=issue_bus.
- issue_bus >= NUM_FWD is illegal. The RTL clamps it to NUM_FWD-1, and a simulation assertion fires.
- Tick, every cycle with ~freeze, for each busy entry:
  - ready_cnt>0: decrement.
  - else fwd_idx==NUM_FWD-1: clear busy (value is in the RF; the RF writes before it reads).
  - else: increment fwd_idx.
- Ordering in one cycle: tick first, then allocation overwrites. Issuing to a register that is still busy (WAW) replaces the entry, so the younger producer wins. Allocation and retirement of the same register in the same cycle results in the entry being allocated.
- Self-dependence: the issuing instruction's own sources see the pre-update state.
- Freeze: no tick and no allocation. stall and fwd_sel keep being driven from the held state.
- Latency: one-cycle update to the registered state. Lookup has zero latency.

Decomposition:
- Shared package holds:
  - REG_ADDR default.
  - Forward select encodings: FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - Standard latency constants: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3.
  - Bus constants: BUS_ALU=0, BUS_LOAD=1.
- Sub-module sb_entry: one register's busy/ready_cnt/fwd_idx with tick and allocate inputs. It is instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
- ALU chain: issue r3 (lat 0, bus 0); next cycle src0=r3 -> stall 0, sel 1; following cycle sel 2; then sel 0 and busy_vec[3]=0.
- Load-use: issue r5 (lat 1, bus 1); next cycle src1=r5 -> stall 1, no allocation for the ID instruction; next cycle stall 0, sel 2; next cycle sel 0.
- Multi-cycle with freeze: issue r6 (lat 3, bus 0), dependent in ID -> stall for 3 cycles. With freeze asserted for 2 of those cycles -> stall for 5 cycles, then sel 1.
- WAW: issue r7 (lat 3), then next cycle issue r7 (lat 0); following lookup of r7 -> stall 0, sel 1. The old entry leaves no residue, and busy clears after 2 more cycles.
- Zero and unused sources:
  - issue r0 -> busy_vec stays 0, and src r0 -> sel 0.
  - src_used=0 on a busy r4 -> stall 0.
- Reset mid-flight: r4 busy (lat 5), assert reset one cycle -> busy_vec=0, stall=0, fwd_sel=0 on the following cycle.
